uart_frame_tx: RTL and testbench

- Parametrised successor to the fixed 5-byte UART send controller.
- Accepts a NUM_BYTES-wide word on a single-cycle `send` request and latches it at accept.
- Serialises it byte by byte into the existing byte-level UART transmitter via a start/done handshake.
- Optionally adds a sync header byte, a selectable byte order and a trailing XOR checksum byte.
- Sits between application logic (key/note reporting to the PC) and the UART TX core.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_byte_mux.sv | 44 ++++
 rtl/uart_frame_tx.sv | 107 ++++++++++
 tb/tb_uart_frame_tx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame transmitter: FSM encodings, the default
// sync byte and the frame-length helper.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    // Bytes per frame: optional header + payload + optional checksum.
    function automatic int frame_total(input int num_bytes, input bit header_en,
                                       input bit csum_en);
        return num_bytes + int'(header_en) + int'(csum_en);
    endfunction

endpackage

// File: rtl/uart_byte_mux.sv
// Selects the byte presented to the TX core for a given frame position:
// header, payload lane (in the configured order) or the running checksum.
module uart_byte_mux
    import uart_pkg::*;
#(
    parameter int         NUM_BYTES   = 5,
    parameter bit         MSB_FIRST   = 1'b0,
    parameter bit         HEADER_EN   = 1'b0,
    parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER,
    parameter bit         CSUM_EN     = 1'b0
) (
    input  logic [8*NUM_BYTES-1:0] data,
    input  logic [4:0]             byte_idx,
    input  logic [7:0]             csum,
    output logic [7:0]             byte_out,
    output logic                   is_payload
);

    localparam int TOTAL = frame_total(NUM_BYTES, HEADER_EN, CSUM_EN);

    logic [4:0] pay_pos;
    logic [4:0] lane;

    always_comb begin
        pay_pos    = byte_idx - 5'(HEADER_EN);
        lane       = MSB_FIRST ? (5'(NUM_BYTES - 1) - pay_pos) : pay_pos;
        byte_out   = 8'h00;
        is_payload = 1'b0;
        if (HEADER_EN && (byte_idx == 5'd0)) begin
            byte_out = HEADER_BYTE;
        end else if (CSUM_EN && (byte_idx == 5'(TOTAL - 1))) begin
            byte_out = csum;
        end else begin
            is_payload = 1'b1;
            // Loop-compare keeps the lane select in range for any byte_idx value.
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (lane == 5'(i)) begin
                    byte_out = data[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Frame-level UART send controller: latches a multi-byte word on send and feeds it
// byte by byte to the byte-level TX core via a start/done handshake.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int         NUM_BYTES   = 5,
    parameter bit         MSB_FIRST   = 1'b0,
    parameter bit         HEADER_EN   = 1'b0,
    parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER,
    parameter bit         CSUM_EN     = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   send,
    input  logic [8*NUM_BYTES-1:0] data,
    input  logic                   uart_busy,
    input  logic                   uart_send_done,
    output logic                   uart_send,
    output logic [7:0]             send_data,
    output logic                   send_done,
    output logic                   flag,
    output logic [1:0]             sta,
    output logic [4:0]             byte_idx
);

    localparam int TOTAL = frame_total(NUM_BYTES, HEADER_EN, CSUM_EN);

    state_t                 state;
    logic [8*NUM_BYTES-1:0] data_q;
    logic [7:0]             csum;
    logic [7:0]             mux_byte;
    logic                   mux_is_payload;

    uart_byte_mux #(
        .NUM_BYTES  (NUM_BYTES),
        .MSB_FIRST  (MSB_FIRST),
        .HEADER_EN  (HEADER_EN),
        .HEADER_BYTE(HEADER_BYTE),
        .CSUM_EN    (CSUM_EN)
    ) u_byte_mux (
        .data      (data_q),
        .byte_idx  (byte_idx),
        .csum      (csum),
        .byte_out  (mux_byte),
        .is_payload(mux_is_payload)
    );

    assign flag = (state == ST_IDLE);
    assign sta  = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            data_q    <= '0;
            csum      <= 8'h00;
            byte_idx  <= 5'd0;
            uart_send <= 1'b0;
            send_data <= 8'h00;
            send_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    send_done <= 1'b0;
                    if (send) begin
                        data_q   <= data;
                        csum     <= 8'h00;
                        byte_idx <= 5'd0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!uart_busy) begin
                        send_data <= mux_byte;
                        uart_send <= 1'b1;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Only the core's done pulse advances; busy is irrelevant here.
                    if (uart_send_done) begin
                        uart_send <= 1'b0;
                        if (mux_is_payload) begin
                            csum <= csum ^ send_data;
                        end
                        if (byte_idx == 5'(TOTAL - 1)) begin
                            send_done <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            byte_idx <= byte_idx + 5'd1;
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_DONE: begin
                    send_done <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    uart_send <= 1'b0;
                    send_done <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: two configurations driven by a behavioural
// TX-core model, with expected byte streams built from frame rules.
module tb_uart_frame_tx;

    localparam int BT = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // DUT A: defaults. DUT B: 3 bytes, MSB first, header and checksum.
    logic        send_a = 1'b0, send_b = 1'b0;
    logic [39:0] data_a = '0;
    logic [23:0] data_b = '0;
    logic        uart_send_a, uart_send_b, send_done_a, send_done_b, flag_a, flag_b;
    logic [7:0]  send_data_a, send_data_b;
    logic [1:0]  sta_a, sta_b;
    logic [4:0]  byte_idx_a, byte_idx_b;

    logic mbusy[2], mdone[2], spur[2], bforce[2];
    logic busy_a, busy_b, done_a, done_b;
    assign busy_a = mbusy[0] | bforce[0];
    assign busy_b = mbusy[1] | bforce[1];
    assign done_a = mdone[0] | spur[0];
    assign done_b = mdone[1] | spur[1];

    logic       usend[2], sdone[2];
    logic [7:0] sdata[2];
    assign usend[0] = uart_send_a;  assign usend[1] = uart_send_b;
    assign sdone[0] = send_done_a;  assign sdone[1] = send_done_b;
    assign sdata[0] = send_data_a;  assign sdata[1] = send_data_b;

    uart_frame_tx u_dut_a (
        .clk(clk), .rst(rst_n), .send(send_a), .data(data_a),
        .uart_busy(busy_a), .uart_send_done(done_a),
        .uart_send(uart_send_a), .send_data(send_data_a), .send_done(send_done_a),
        .flag(flag_a), .sta(sta_a), .byte_idx(byte_idx_a)
    );

    uart_frame_tx #(.NUM_BYTES(3), .MSB_FIRST(1'b1), .HEADER_EN(1'b1), .CSUM_EN(1'b1)) u_dut_b (
        .clk(clk), .rst(rst_n), .send(send_b), .data(data_b),
        .uart_busy(busy_b), .uart_send_done(done_b),
        .uart_send(uart_send_b), .send_data(send_data_b), .send_done(send_done_b),
        .flag(flag_b), .sta(sta_b), .byte_idx(byte_idx_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt[2];
    int byte_cnt[2];
    logic       prev_us[2], prev_done[2];
    logic [7:0] held[2];
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Frame rules: [header] + payload bytes in wire order + [XOR of payload].
    task automatic push_frame(input int d, input logic [127:0] w);
        int         n;
        bit         msb, hdr, cs;
        logic [7:0] lanes[$];
        logic [7:0] frame[$];
        logic [7:0] x;
        if (d == 0) begin n = 5; msb = 0; hdr = 0; cs = 0; end
        else        begin n = 3; msb = 1; hdr = 1; cs = 1; end
        for (int i = 0; i < n; i++) lanes.push_back(w[i*8 +: 8]);
        if (msb) lanes.reverse();
        x = 8'h00;
        foreach (lanes[i]) x = x ^ lanes[i];
        if (hdr) frame.push_back(8'hA5);
        foreach (lanes[i]) frame.push_back(lanes[i]);
        if (cs) frame.push_back(x);
        foreach (frame[i]) begin
            if (d == 0) exp_q0.push_back(frame[i]);
            else        exp_q1.push_back(frame[i]);
        end
    endtask

    // Byte-level TX core: busy for BT cycles after a start, then a one-cycle done.
    task automatic tx_model(input int d);
        forever begin
            @(posedge clk); #1;
            if (usend[d] && !mbusy[d]) begin
                mbusy[d] = 1'b1;
                repeat (BT) @(posedge clk);
                #1 mdone[d] = 1'b1;
                @(posedge clk);
                #1 mdone[d] = 1'b0;
                mbusy[d] = 1'b0;
            end
        end
    endtask

    task automatic mon_step(input int d);
        int         qs;
        logic [7:0] e;
        qs = (d == 0) ? exp_q0.size() : exp_q1.size();
        if (usend[d] && !prev_us[d]) begin
            byte_cnt[d]++;
            if (qs == 0) begin
                chk($sformatf("unexpected_byte_%0d", d), 32'(sdata[d]), 32'hFFFF_FFFF);
            end else begin
                e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                chk($sformatf("byte_%0d", d), 32'(sdata[d]), 32'(e));
            end
            held[d] = sdata[d];
        end else if (usend[d] && prev_us[d]) begin
            chk($sformatf("byte_hold_%0d", d), 32'(sdata[d]), 32'(held[d]));
        end
        if (sdone[d]) begin
            qs = (d == 0) ? exp_q0.size() : exp_q1.size();
            chk($sformatf("done_single_cycle_%0d", d), 32'(prev_done[d]), 32'd0);
            chk($sformatf("frame_complete_%0d", d), 32'(qs), 32'd0);
            done_cnt[d]++;
        end
        prev_us[d]   = usend[d];
        prev_done[d] = sdone[d];
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            mbusy[d] = 0; mdone[d] = 0; spur[d] = 0; bforce[d] = 0;
            done_cnt[d] = 0; byte_cnt[d] = 0; prev_us[d] = 0; prev_done[d] = 0; held[d] = 0;
        end
        fork
            tx_model(0);
            tx_model(1);
        join_none
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) mon_step(d);
        end
    end

    task automatic fire(input int d, input logic [127:0] w);
        push_frame(d, w);
        if (d == 0) begin data_a = w[39:0]; send_a = 1'b1; end
        else        begin data_b = w[23:0]; send_b = 1'b1; end
        @(posedge clk); #2;
        send_a = 1'b0;
        send_b = 1'b0;
    endtask

    task automatic wait_done(input int d, input int prev);
        int k = 0;
        while (done_cnt[d] == prev && k < 3000) begin
            @(posedge clk); #2;
            k++;
        end
        chk($sformatf("frame_done_count_%0d", d), 32'(done_cnt[d]), 32'(prev + 1));
    endtask

    task automatic wait_bytes(input int d, input int target);
        int k = 0;
        while (byte_cnt[d] < target && k < 3000) begin
            @(posedge clk); #2;
            k++;
        end
        chk($sformatf("byte_reached_%0d", d), 32'(byte_cnt[d] >= target), 32'd1);
    endtask

    initial begin
        int           base, bbase;
        logic [127:0] w;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_uart_send", 32'(uart_send_a), 32'd0);
        chk("reset_send_done", 32'(send_done_a), 32'd0);
        chk("reset_flag", 32'(flag_a), 32'd1);
        chk("reset_sta", 32'(sta_a), 32'd0);
        chk("reset_byte_idx", 32'(byte_idx_a), 32'd0);
        chk("reset_send_data", 32'(send_data_a), 32'd0);
        chk("reset_flag_b", 32'(flag_b), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Directed frames.
        base = done_cnt[0]; bbase = byte_cnt[0];
        fire(0, 128'h05_04_03_02_01);
        chk("accept_sta", 32'(sta_a), 32'd1);
        wait_done(0, base);
        chk("five_byte_starts", 32'(byte_cnt[0] - bbase), 32'd5);
        @(posedge clk); #2;
        chk("flag_after_frame", 32'(flag_a), 32'd1);

        base = done_cnt[1]; bbase = byte_cnt[1];
        fire(1, 128'h0F00F0);
        wait_done(1, base);
        chk("b_byte_starts", 32'(byte_cnt[1] - bbase), 32'd5);
        @(posedge clk); #2;
        chk("flag_b_after_frame", 32'(flag_b), 32'd1);

        // Random frames on either configuration.
        for (int r = 0; r < 8; r++) begin
            int d;
            d = int'($urandom_range(0, 1));
            w = {$urandom, $urandom, $urandom, $urandom};
            base = done_cnt[d];
            fire(d, w);
            wait_done(d, base);
            repeat (int'($urandom_range(1, 3))) @(posedge clk);
            #2;
        end

        // Core held busy after accept, with a stray done pulse while waiting.
        bforce[0] = 1'b1;
        base = done_cnt[0];
        fire(0, 128'h1122334455);
        for (int i = 0; i < 50; i++) begin
            spur[0] = (i == 10);
            @(posedge clk); #2;
            chk("busy_hold_no_send", 32'(uart_send_a), 32'd0);
            if (i == 10) begin
                chk("spurious_done_idx", 32'(byte_idx_a), 32'd0);
                chk("spurious_done_sta", 32'(sta_a), 32'd1);
            end
        end
        spur[0] = 1'b0;
        bforce[0] = 1'b0;
        @(posedge clk); #2;
        chk("send_after_busy_falls", 32'(uart_send_a), 32'd1);
        wait_done(0, base);

        // Data change and a second send while a frame is in flight.
        @(posedge clk); #2;
        base = done_cnt[0];
        fire(0, 128'hCAFEBABE42);
        wait_bytes(0, byte_cnt[0] + 2);
        data_a = 40'hDEADBEEF99;
        send_a = 1'b1;
        @(posedge clk); #2;
        send_a = 1'b0;
        wait_done(0, base);
        repeat (60) @(posedge clk);
        #2;
        chk("single_done_after_resend", 32'(done_cnt[0]), 32'(base + 1));
        chk("idle_after_resend", 32'(sta_a), 32'd0);

        // Reset in the middle of the third byte.
        base = done_cnt[0];
        bbase = byte_cnt[0];
        fire(0, 128'h8877665544);
        wait_bytes(0, bbase + 3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_uart_send", 32'(uart_send_a), 32'd0);
        chk("abort_flag", 32'(flag_a), 32'd1);
        chk("abort_byte_idx", 32'(byte_idx_a), 32'd0);
        exp_q0.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #2;
        chk("no_done_after_abort", 32'(done_cnt[0]), 32'(base));
        bbase = byte_cnt[0];
        fire(0, 128'h0A0B0C0D0E);
        wait_done(0, base);
        chk("frame_after_abort_bytes", 32'(byte_cnt[0] - bbase), 32'd5);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
